// File: rtl/rice_pkg.sv
// Shared definitions for the Rice encoder front end: widths, the default
// parameter clamp, the scheduler read-FSM states and the zigzag mapping.
package rice_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int PARAM_W       = 4;
  localparam int MAX_PARAM_DEF = 14;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_SEARCH,
    RD_ANNOUNCE,
    RD_DRAIN
  } rd_state_e;

  // Signed residual to unsigned magnitude: s<0 ? -2s-1 : 2s. The encoder
  // uses the same mapping, so the sums here match what it will code.
  function automatic logic [SAMPLE_W-1:0] zigzag(input logic signed [SAMPLE_W-1:0] s);
    return {s[SAMPLE_W-2:0], 1'b0} ^ {SAMPLE_W{s[SAMPLE_W-1]}};
  endfunction

endpackage

// File: rtl/rice_pingpong_buffer.sv
// Two-bank partition store: one write port and one registered read port.
// Each port is addressed by a bank-select bit and a partition offset.
module rice_pingpong_buffer
  import rice_pkg::*;
#(
  parameter int PART_LOG2 = 4
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                wr_en_i,
  input  logic                wr_bank_i,
  input  logic [PART_LOG2-1:0] wr_addr_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic                rd_bank_i,
  input  logic [PART_LOG2-1:0] rd_addr_i,
  output logic [SAMPLE_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 << PART_LOG2;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rd_data_q;

  // Sample storage write port.
  // NOTE: the storage array has no reset; stale contents are never read
  // because a bank is only drained after it has been completely refilled.
  always_ff @(posedge iClock) begin
    if (wr_en_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  // Registered read port; cleared by reset so the encoder sees 0 afterwards.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rice_param_scheduler.sv
// Rice parameter scheduler: fills one partition bank while draining the
// other, picks k from the partition's zigzag magnitude sum, announces k
// once, then replays the partition to the encoder one sample per cycle.
module rice_param_scheduler
  import rice_pkg::*;
#(
  parameter int PART_LOG2 = 4,
  parameter int MAX_PARAM = MAX_PARAM_DEF
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iValid,
  input  logic signed [SAMPLE_W-1:0] iSample,
  output logic                       oReady,
  output logic                       oParamValid,
  output logic [PARAM_W-1:0]         oRiceParam,
  output logic                       oEncValid,
  output logic signed [SAMPLE_W-1:0] oEncSample
);

  localparam int N     = 1 << PART_LOG2;
  localparam int SUM_W = SAMPLE_W + PART_LOG2;
  localparam int CMP_W = SUM_W + 1;

  // Write side state
  logic                       wr_bank_q, wr_bank_d;
  logic [PART_LOG2-1:0]       wr_cnt_q, wr_cnt_d;
  logic [1:0]                 full_q, full_d;
  logic [1:0][SUM_W-1:0]      sum_q, sum_d;
  logic                       ready_q;

  // Read side state
  rd_state_e                  state_q;
  logic                       rd_bank_q;
  logic [PARAM_W-1:0]         k_q;
  logic [PART_LOG2-1:0]       rd_cnt_q;
  logic                       param_valid_q;
  logic [PARAM_W-1:0]         rice_param_q;
  logic                       enc_valid_q;

  logic                       accept;
  logic                       wr_last;
  logic                       drain_last;
  logic                       rd_en;
  logic [PART_LOG2-1:0]       rd_addr;
  logic [PARAM_W:0]           shamt;
  logic [CMP_W-1:0]           threshold;
  logic                       k_found;
  logic [SAMPLE_W-1:0]        rd_data;

  assign accept     = iValid && ready_q;
  assign wr_last    = accept && (wr_cnt_q == PART_LOG2'(N - 1));
  assign drain_last = (state_q == RD_DRAIN) && (rd_cnt_q == PART_LOG2'(N - 1));

  // Address 0 is read while announcing, the rest while draining.
  assign rd_en   = (state_q == RD_ANNOUNCE) || (state_q == RD_DRAIN);
  assign rd_addr = (state_q == RD_DRAIN) ? rd_cnt_q : '0;

  // k search test: N * 2^(k+1) > sum, or the clamp has been reached.
  assign shamt     = {1'b0, k_q} + (PARAM_W + 1)'(1);
  assign threshold = CMP_W'(N) << shamt;
  assign k_found   = (threshold > {1'b0, sum_q[rd_bank_q]}) ||
                     (k_q == PARAM_W'(MAX_PARAM));

  // Next-state for the fill pointer, full flags and partition sums.
  // NOTE: every target gets its default first with blocking assignments,
  // so no path through this block leaves a latch behind.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    full_d    = full_q;
    sum_d     = sum_q;
    if (accept) begin
      sum_d[wr_bank_q] = sum_q[wr_bank_q] + SUM_W'(zigzag(iSample));
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    // The drained bank is always the other one, so both updates stand.
    if (drain_last) begin
      full_d[rd_bank_q] = 1'b0;
      sum_d[rd_bank_q]  = '0;
    end
  end

  // Write side registers; oReady looks at the flags as they will be after this edge.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      full_q    <= '0;
      sum_q     <= '0;
      ready_q   <= 1'b1;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      full_q    <= full_d;
      sum_q     <= sum_d;
      ready_q   <= ~full_d[wr_bank_d];
    end
  end

  // Read FSM: wait for a full bank, search k, announce it, replay N samples.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q       <= RD_IDLE;
      rd_bank_q     <= 1'b0;
      k_q           <= '0;
      rd_cnt_q      <= '0;
      param_valid_q <= 1'b0;
      rice_param_q  <= '0;
      enc_valid_q   <= 1'b0;
    end else begin
      param_valid_q <= 1'b0;
      enc_valid_q   <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (full_q[rd_bank_q]) begin
            k_q     <= '0;
            state_q <= RD_SEARCH;
          end
        end
        RD_SEARCH: begin
          if (k_found) begin
            rice_param_q  <= k_q;
            param_valid_q <= 1'b1;
            state_q       <= RD_ANNOUNCE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        RD_ANNOUNCE: begin
          // Address 0 is read this cycle; it lands the cycle after the pulse.
          enc_valid_q <= 1'b1;
          rd_cnt_q    <= PART_LOG2'(1);
          state_q     <= RD_DRAIN;
        end
        RD_DRAIN: begin
          enc_valid_q <= 1'b1;
          rd_cnt_q    <= rd_cnt_q + 1'b1;
          if (drain_last) begin
            rd_bank_q <= ~rd_bank_q;
            state_q   <= RD_IDLE;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  rice_pingpong_buffer #(
    .PART_LOG2 (PART_LOG2)
  ) u_buffer (
    .iClock    (iClock),
    .iReset    (iReset),
    .wr_en_i   (accept),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (iSample),
    .rd_en_i   (rd_en),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign oReady      = ready_q;
  assign oParamValid = param_valid_q;
  assign oRiceParam  = rice_param_q;
  assign oEncValid   = enc_valid_q;
  assign oEncSample  = rd_data;

  // A bank finishing its fill must never be the bank being freed.
  a_no_bank_collision : assert property (
    @(posedge iClock) disable iff (iReset)
      !(wr_last && drain_last && (wr_bank_q == rd_bank_q))
  );

endmodule

// File: tb/tb_rice_param_scheduler.sv
// Bench for rice_param_scheduler: randomised and directed partitions are
// scored against a reference that computes k straight from the partition
// magnitude sum; a monitor checks every parameter pulse and replayed sample.
module tb_rice_param_scheduler;

  localparam int PART_LOG2 = 4;
  localparam int N         = 1 << PART_LOG2;
  localparam int MAX_K     = 14;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iValid = 1'b0;
  logic [15:0] iSample = '0;
  logic        oReady;
  logic        oParamValid;
  logic [3:0]  oRiceParam;
  logic        oEncValid;
  logic [15:0] oEncSample;

  always #5 iClock = ~iClock;

  rice_param_scheduler #(
    .PART_LOG2 (PART_LOG2),
    .MAX_PARAM (MAX_K)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iValid      (iValid),
    .iSample     (iSample),
    .oReady      (oReady),
    .oParamValid (oParamValid),
    .oRiceParam  (oRiceParam),
    .oEncValid   (oEncValid),
    .oEncSample  (oEncSample)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] part_buf[$];
  int          exp_param_q[$];
  logic [15:0] exp_samp_q[$];

  function automatic int ref_k(input logic [15:0] samples[$]);
    longint sum = 0;
    foreach (samples[i]) begin
      int s = int'($signed(samples[i]));
      sum += (s < 0) ? (-2 * s - 1) : (2 * s);
    end
    for (int k = 0; k < MAX_K; k++) begin
      if ((longint'(N) << (k + 1)) > sum) return k;
    end
    return MAX_K;
  endfunction

  task automatic model_accept(input logic [15:0] s);
    part_buf.push_back(s);
    if (part_buf.size() == N) begin
      exp_param_q.push_back(ref_k(part_buf));
      foreach (part_buf[i]) exp_samp_q.push_back(part_buf[i]);
      part_buf.delete();
    end
  endtask

  // ---------------- monitor ----------------
  logic rst_prev = 1'b1;
  bit   mon_en = 1'b0;
  int   remaining = 0;
  int   seen_in_part = 0;
  int   total_params = 0;
  int   total_samps = 0;

  task automatic model_flush();
    part_buf.delete();
    exp_param_q.delete();
    exp_samp_q.delete();
    remaining    = 0;
    seen_in_part = 0;
  endtask

  always @(posedge iClock) rst_prev <= iReset;

  always @(negedge iClock) begin
    if (mon_en) begin
      if (rst_prev) begin
        check("rst_ready", oReady, 1);
        check("rst_param_valid", oParamValid, 0);
        check("rst_rice_param", oRiceParam, 0);
        check("rst_enc_valid", oEncValid, 0);
        check("rst_enc_sample", oEncSample, 0);
      end else if (oParamValid) begin
        check("param_enc_low", oEncValid, 0);
        check("param_prev_done", remaining, 0);
        if (exp_param_q.size() == 0) fail_now("param_unexpected");
        else check("rice_param", oRiceParam, exp_param_q.pop_front());
        total_params++;
        remaining    = N;
        seen_in_part = 0;
      end else if (remaining > 0) begin
        check("enc_contiguous", oEncValid, 1);
        if (oEncValid) begin
          if (exp_samp_q.size() == 0) fail_now("enc_unexpected");
          else check("enc_sample", oEncSample, exp_samp_q.pop_front());
          remaining--;
          seen_in_part++;
          total_samps++;
        end
      end else if (oEncValid) begin
        fail_now("enc_outside_partition");
      end
    end
  end

  // ---------------- driver ----------------
  bit saw_stall = 1'b0;

  task automatic drive(input bit v, input logic [15:0] s, output bit acc);
    iValid = v;
    iSample = s;
    @(negedge iClock);
    acc = v && (oReady === 1'b1);
    if (v && oReady !== 1'b1) saw_stall = 1'b1;
    if (acc) model_accept(s);
    @(posedge iClock);
    #1;
  endtask

  task automatic send_sample(input logic [15:0] s);
    bit acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) drive(1'b1, s, acc);
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic send_ramp(input int base, input int step);
    for (int i = 0; i < N; i++) send_sample(16'(base + i * step));
    iValid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      if (exp_param_q.size() == 0 && exp_samp_q.size() == 0 && remaining == 0)
        done = 1'b1;
      else begin
        @(posedge iClock);
        #1;
      end
    end
    if (!done) fail_now("drain_timeout");
  endtask

  task automatic do_reset(input int cycles, input bit v);
    iReset = 1'b1;
    iValid = v;
    for (int c = 0; c < cycles; c++) begin
      @(posedge iClock);
      #1;
      mon_en = 1'b1;
      model_flush();
    end
    iReset = 1'b0;
    iValid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0;
    bit acc;
    bit ok;

    // Reset held 3 cycles with iValid asserted.
    do_reset(3, 1'b1);
    @(negedge iClock);
    check("post_rst_ready", oReady, 1);
    check("post_rst_enc_valid", oEncValid, 0);
    @(posedge iClock);
    #1;

    // Directed partitions: zeros (k=0), +8 (k=4), ramp, clamp.
    send_ramp(0, 0);
    wait_drain();
    send_ramp(8, 0);
    wait_drain();
    send_ramp(-3, 8);
    wait_drain();
    send_ramp(-32768, 0);
    wait_drain();

    // Five back-to-back partitions with iValid held high.
    p0 = total_params;
    s0 = total_samps;
    saw_stall = 1'b0;
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < N; i++) send_sample(16'(p * 1000 - 300 + i * 37));
    iValid = 1'b0;
    wait_drain();
    check("b2b_stall_seen", saw_stall, 1);
    check("b2b_param_count", total_params - p0, 5);
    check("b2b_sample_count", total_samps - s0, 5 * N);

    // Reset in the middle of a drain.
    send_ramp(8, 0);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (remaining > 0 && seen_in_part >= 7) ok = 1'b1;
      else begin
        @(posedge iClock);
        #1;
      end
    end
    if (!ok) fail_now("mid_drain_wait_timeout");
    do_reset(1, 1'b0);
    @(negedge iClock);
    check("mid_rst_enc_valid", oEncValid, 0);
    check("mid_rst_ready", oReady, 1);
    @(posedge iClock);
    #1;
    p0 = total_params;
    s0 = total_samps;
    send_ramp(8, 0);
    wait_drain();
    check("post_rst_param_count", total_params - p0, 1);
    check("post_rst_sample_count", total_samps - s0, N);

    // Random partitions with random magnitudes and idle gaps.
    for (int p = 0; p < 8; p++) begin
      int mag = $urandom_range(0, 15);
      for (int i = 0; i < N; i++) begin
        logic [15:0] s;
        int v = int'($urandom & ((32'd1 << mag) - 1));
        if ($urandom_range(0, 1) == 1) v = -v - 1;
        s = 16'(v);
        if ($urandom_range(0, 3) == 0) drive(1'b0, 16'h0, acc);
        send_sample(s);
      end
    end
    iValid = 1'b0;
    wait_drain();
    check("final_partial_empty", part_buf.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
